// File: rtl/stream_arb_2to1_pkg.sv
// Shared encodings for the 2:1 round-robin packet arbiter.
// Grant states and selector codes are shared with the selector.
package stream_arb_2to1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_arb_2to1_if.sv
// Valid/ready packet stream bundle.
// The master drives the beat, and the slave answers with ready.
interface stream_arb_2to1_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (
        output valid, data, last,
        input  ready
    );

    modport slave (
        input  valid, data, last,
        output ready
    );
endinterface

// File: rtl/stream_arb_2to1_mux.sv
// Vectorised 2:1 selector, steered by the arbiter's sel line.
// A sel of 0 passes in0 (stream A), and a sel of 1 passes in1 (stream B).
module stream_arb_2to1_mux
    import stream_arb_2to1_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    assign out = (sel == SEL_B) ? in1 : in0;

endmodule

// File: rtl/stream_arb_2to1.sv
// Round-robin 2:1 packet arbiter with packet lock and a registered output.
// Arbitration takes one idle cycle per grant, and the payload passes through the shared selector.
module stream_arb_2to1
    import stream_arb_2to1_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    stream_arb_2to1_if.slave  a,
    stream_arb_2to1_if.slave  b,
    stream_arb_2to1_if.master y,
    output logic sel
);

    state_t            state;
    logic              prio;
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              space;
    logic              take;
    logic [DATA_W:0]   pick;

    assign space   = !vld_q | y.ready;
    assign a.ready = (state == GNT_A) & space;
    assign b.ready = (state == GNT_B) & space;
    assign take    = (a.valid & a.ready)
                   | (b.valid & b.ready);

    assign y.valid = vld_q;
    assign y.data  = data_q;
    assign y.last  = last_q;

    // In a grant state, sel already equals the granted stream.
    stream_arb_2to1_mux #(
        .W(DATA_W + 1)
    ) u_mux (
        .sel(sel),
        .in0({a.last, a.data}),
        .in1({b.last, b.data}),
        .out(pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            prio   <= SEL_A;
            sel    <= SEL_A;
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            if (take) begin
                vld_q  <= 1'b1;
                data_q <= pick[DATA_W-1:0];
                last_q <= pick[DATA_W];
            end else if (y.ready) begin
                vld_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (a.valid && (prio == SEL_A || !b.valid)) begin
                        state <= GNT_A;
                        sel   <= SEL_A;
                    end else if (b.valid) begin
                        state <= GNT_B;
                        sel   <= SEL_B;
                    end
                end
                GNT_A: begin
                    if (take && pick[DATA_W]) begin
                        state <= IDLE;
                        prio  <= SEL_B;
                    end
                end
                GNT_B: begin
                    if (take && pick[DATA_W]) begin
                        state <= IDLE;
                        prio  <= SEL_A;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Directed bench for stream_arb_2to1.
// Each beat is encoded as {last, data[7:0]}.
module tb_stream_arb_2to1;

    logic clk = 1'b0;
    logic rst;
    logic sel;

    always #5 clk = ~clk;

    stream_arb_2to1_if #(.DATA_W(8)) a_if ();
    stream_arb_2to1_if #(.DATA_W(8)) b_if ();
    stream_arb_2to1_if #(.DATA_W(8)) y_if ();

    stream_arb_2to1 #(
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a_if),
        .b(b_if),
        .y(y_if),
        .sel(sel)
    );

    logic [8:0] aq[$];
    logic [8:0] bq[$];
    logic [8:0] yq[$];
    logic       selq[$];
    int         yc[$];
    int         ac[$];
    int         cyc;
    int         afires;
    logic       a_en;
    logic       b_en;
    logic       fa, fb, fy;
    int         errors;
    int         checks;

    // Source and sink model: fires are sampled at the edge, and drives settle 2 time units later.
    initial begin
        cyc    = 0;
        afires = 0;
        a_if.valid = 1'b0;
        a_if.data  = '0;
        a_if.last  = 1'b0;
        b_if.valid = 1'b0;
        b_if.data  = '0;
        b_if.last  = 1'b0;
        forever begin
            @(posedge clk);
            fa = !rst && a_if.valid && a_if.ready;
            fb = !rst && b_if.valid && b_if.ready;
            fy = !rst && y_if.valid && y_if.ready;
            cyc++;
            if (fa) begin
                void'(aq.pop_front());
                selq.push_back(sel);
                ac.push_back(cyc);
                afires++;
            end
            if (fb) begin
                void'(bq.pop_front());
                selq.push_back(sel);
            end
            if (fy) begin
                yq.push_back({y_if.last, y_if.data});
                yc.push_back(cyc);
            end
            #2;
            a_if.valid = a_en && (aq.size() > 0);
            if (aq.size() > 0) {a_if.last, a_if.data} = aq[0];
            b_if.valid = b_en && (bq.size() > 0);
            if (bq.size() > 0) {b_if.last, b_if.data} = bq[0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        yq.delete();
        selq.delete();
        yc.delete();
        ac.delete();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        a_en = 1'b0;
        b_en = 1'b0;
        aq.delete();
        bq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        y_if.ready = 1'b1;
        aq = '{9'h001, 9'h102};
        bq = '{9'h003, 9'h104};
        a_en = 1'b1;
        b_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks += 5;
            if (y_if.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_y_valid[%0d]: got %b want 0", k, y_if.valid);
            end
            if (y_if.data !== 8'h00) begin
                errors++;
                $display("FAIL reset_y_data[%0d]: got %h want 00", k, y_if.data);
            end
            if (sel !== 1'b0) begin
                errors++;
                $display("FAIL reset_sel[%0d]: got %b want 0", k, sel);
            end
            if (a_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_a_ready[%0d]: got %b want 0", k, a_if.ready);
            end
            if (b_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_b_ready[%0d]: got %b want 0", k, b_if.ready);
            end
        end
        do_reset();
    endtask

    task automatic test_tie();
        logic [8:0] exp_y[6] = '{9'h011, 9'h012, 9'h113,
                                 9'h021, 9'h022, 9'h123};
        logic       exp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int n = 0;
        clear_logs();
        y_if.ready = 1'b1;
        aq = '{9'h011, 9'h012, 9'h113};
        bq = '{9'h021, 9'h022, 9'h123};
        a_en = 1'b1;
        b_en = 1'b1;
        while (yq.size() < 6 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (yq.size() != 6 || selq.size() != 6) begin
            errors++;
            $display("FAIL tie_count: got %0d/%0d beats want 6/6", yq.size(), selq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks += 2;
                if (yq[i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL tie_beat[%0d]: got %h want %h", i, yq[i], exp_y[i]);
                end
                if (selq[i] !== exp_s[i]) begin
                    errors++;
                    $display("FAIL tie_sel[%0d]: got %b want %b", i, selq[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_y[4] = '{9'h031, 9'h032, 9'h033, 9'h134};
        int n = 0;
        clear_logs();
        y_if.ready = 1'b1;
        aq = '{9'h031, 9'h032, 9'h033, 9'h134};
        a_en = 1'b1;
        b_en = 1'b0;
        while (yq.size() < 2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        y_if.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 3;
            if (y_if.valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_y_valid[%0d]: got %b want 1", k, y_if.valid);
            end
            if (y_if.data !== 8'h33) begin
                errors++;
                $display("FAIL bp_y_data[%0d]: got %h want 33", k, y_if.data);
            end
            if (a_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_a_ready[%0d]: got %b want 0", k, a_if.ready);
            end
            @(posedge clk);
            #1;
        end
        y_if.ready = 1'b1;
        n = 0;
        while (yq.size() < 4 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (yq.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 4", yq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (yq[i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL bp_beat[%0d]: got %h want %h", i, yq[i], exp_y[i]);
                end
            end
            checks += 3;
            if (yc[1] - yc[0] != 1) begin
                errors++;
                $display("FAIL bp_gap01: got %0d want 1", yc[1] - yc[0]);
            end
            if (yc[2] - yc[1] != 5) begin
                errors++;
                $display("FAIL bp_stall: got %0d want 5", yc[2] - yc[1]);
            end
            if (yc[3] - yc[2] != 1) begin
                errors++;
                $display("FAIL bp_gap23: got %0d want 1", yc[3] - yc[2]);
            end
        end
    endtask

    task automatic test_lock();
        logic [8:0] exp_y[6] = '{9'h041, 9'h042, 9'h043, 9'h144,
                                 9'h04A, 9'h14B};
        int base;
        int n = 0;
        do_reset();
        base = afires;
        y_if.ready = 1'b1;
        aq = '{9'h041, 9'h042, 9'h043, 9'h144};
        bq = '{9'h04A, 9'h14B};
        a_en = 1'b1;
        b_en = 1'b1;
        while (afires - base < 4 && n < 40) begin
            @(negedge clk);
            checks++;
            if (b_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL lock_b_ready[%0d]: got %b want 0", n, b_if.ready);
            end
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (yq.size() < 6 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (yq.size() != 6) begin
            errors++;
            $display("FAIL lock_count: got %0d beats want 6", yq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (yq[i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL lock_beat[%0d]: got %h want %h", i, yq[i], exp_y[i]);
                end
            end
        end
    endtask

    task automatic test_rotation();
        int n = 0;
        clear_logs();
        y_if.ready = 1'b1;
        aq = '{9'h151, 9'h152, 9'h153};
        a_en = 1'b1;
        b_en = 1'b0;
        while (ac.size() < 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (ac.size() != 3) begin
            errors++;
            $display("FAIL rot_count: got %0d A beats want 3", ac.size());
        end else begin
            checks += 2;
            if (ac[1] - ac[0] != 2) begin
                errors++;
                $display("FAIL rot_gap01: got %0d want 2", ac[1] - ac[0]);
            end
            if (ac[2] - ac[1] != 2) begin
                errors++;
                $display("FAIL rot_gap12: got %0d want 2", ac[2] - ac[1]);
            end
        end
        aq = '{9'h161};
        bq = '{9'h171};
        b_en = 1'b1;
        n = 0;
        while (selq.size() < 5 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (selq.size() != 5) begin
            errors++;
            $display("FAIL rot_tie_count: got %0d grants want 5", selq.size());
        end else begin
            checks += 2;
            if (selq[3] !== 1'b1) begin
                errors++;
                $display("FAIL rot_tie_first: got sel %b want 1", selq[3]);
            end
            if (selq[4] !== 1'b0) begin
                errors++;
                $display("FAIL rot_tie_second: got sel %b want 0", selq[4]);
            end
        end
        n = 0;
        while (yq.size() < 5 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (yq.size() != 5 || yq[3] !== 9'h171) begin
            errors++;
            $display("FAIL rot_tie_beat: got %0d beats, got beat4 %h want 171",
                     yq.size(), (yq.size() > 3) ? yq[3] : 9'h000);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int n = 0;
        clear_logs();
        base = afires;
        y_if.ready = 1'b1;
        aq = '{9'h081, 9'h082, 9'h083, 9'h184};
        a_en = 1'b1;
        b_en = 1'b0;
        while (afires - base < 2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 4;
        if (y_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL mrst_y_valid: got %b want 0", y_if.valid);
        end
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL mrst_sel: got %b want 0", sel);
        end
        if (a_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL mrst_a_ready: got %b want 0", a_if.ready);
        end
        if (b_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL mrst_b_ready: got %b want 0", b_if.ready);
        end
        rst = 1'b0;
        aq.delete();
        bq.delete();
        clear_logs();
        aq = '{9'h1A1};
        bq = '{9'h1B1};
        b_en = 1'b1;
        n = 0;
        while (yq.size() < 2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (yq.size() != 2) begin
            errors++;
            $display("FAIL mrst_count: got %0d beats want 2", yq.size());
        end else begin
            checks += 2;
            if (yq[0] !== 9'h1A1) begin
                errors++;
                $display("FAIL mrst_first: got %h want 1a1", yq[0]);
            end
            if (yq[1] !== 9'h1B1) begin
                errors++;
                $display("FAIL mrst_second: got %h want 1b1", yq[1]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_tie();
        test_backpressure();
        test_lock();
        test_rotation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
